// File: rtl/l2_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// l2_bus_arbiter_pkg: shared types and constants for the L2 bus arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package l2_bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic ARB_PORT_FETCH = 1'b0;
  localparam logic ARB_PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   addr;
    logic                    write;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] wstrb;
  } arb_req_t;

endpackage

`default_nettype wire

// File: rtl/l2_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// l2_bus_arbiter_if: requester-side and L2-side signals of the arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface l2_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]                   req_valid;
  logic [1:0][ADDR_W-1:0]       req_addr;
  logic [1:0]                   req_write;
  logic [1:0][DATA_W-1:0]       req_wdata;
  logic [1:0][DATA_W/8-1:0]     req_wstrb;
  logic [1:0]                   req_ready;
  logic [1:0]                   resp_valid;
  logic [DATA_W-1:0]            resp_rdata;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_write;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W/8-1:0]          mem_wstrb;
  logic                         mem_resp_valid;
  logic [DATA_W-1:0]            mem_resp_rdata;
  logic                         error;

  // Environment side: requesters plus the L2 model.
  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb, error
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_addr, mem_write, mem_wdata, mem_wstrb, error
  );

endinterface

`default_nettype wire

// File: rtl/l2_bus_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// l2_bus_arbiter_rr_pick2: combinational two-way round-robin/fixed picker.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module l2_bus_arbiter_rr_pick2
  import l2_bus_arbiter_pkg::*;
(
  input  wire [1:0] i_valid,
  input  wire       i_last,
  input  wire       i_fixed_prio,
  output logic      o_grant,
  output logic      o_any
);

  always_comb begin
    o_any   = |i_valid;
    o_grant = ARB_PORT_FETCH;
    if (i_valid == 2'b11) begin
      // Tie: the data port wins outright in fixed mode, else alternate.
      o_grant = i_fixed_prio ? ARB_PORT_DATA : ~i_last;
    end else begin
      o_grant = i_valid[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_bus_arbiter.sv
// ----------------------------------------------------------------------------
// l2_bus_arbiter: shares one L2 port between fetch and data requesters.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module l2_bus_arbiter
  import l2_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b0,
  parameter int TIMEOUT   = 1023
) (
  input  wire             clk,
  input  wire             rst,
  l2_bus_arbiter_if.slave bus
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic                 w_grant;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_resp_fire;
  logic                 w_tmo_fire;
  logic                 r_owner;
  logic                 r_last_grant;
  logic [c_cnt_w-1:0]   r_tmo_cnt;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic                 r_mem_write;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [DATA_W/8-1:0]  r_mem_wstrb;
  logic [1:0]           r_resp_valid;
  logic [DATA_W-1:0]    r_resp_rdata;
  logic                 r_error;

  l2_bus_arbiter_rr_pick2 u_pick (
    .i_valid      (bus.req_valid),
    .i_last       (r_last_grant),
    .i_fixed_prio (DATA_PRIO),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_resp_fire       = 1'b0;
    w_tmo_fire        = 1'b0;
    bus.req_ready     = 2'b00;
    bus.mem_req_valid = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          bus.req_ready[w_grant] = 1'b1;
          w_accept               = 1'b1;
          w_state_nxt            = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A real response on the final WAIT cycle beats the timeout.
        if (bus.mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_tmo_fire  = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= ARB_PORT_FETCH;
      r_last_grant <= ARB_PORT_DATA;
      r_tmo_cnt    <= '0;
      r_mem_addr   <= '0;
      r_mem_write  <= 1'b0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
      r_error      <= 1'b0;
    end else begin
      r_resp_valid <= 2'b00;
      if (w_accept) begin
        r_mem_addr   <= bus.req_addr[w_grant];
        r_mem_write  <= bus.req_write[w_grant];
        r_mem_wdata  <= bus.req_wdata[w_grant];
        r_mem_wstrb  <= bus.req_wstrb[w_grant];
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == ARB_ISSUE && bus.mem_req_ready) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ARB_WAIT && !w_tmo_fire) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_resp_fire) begin
        r_resp_valid[r_owner] <= 1'b1;
        r_resp_rdata          <= bus.mem_resp_rdata;
      end else if (w_tmo_fire) begin
        r_resp_valid[r_owner] <= 1'b1;
        r_resp_rdata          <= '0;
        r_error               <= 1'b1;
      end
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_l2_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_bus_arbiter: directed self-checking bench for l2_bus_arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_l2_bus_arbiter;
  import l2_bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  l2_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  l2_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  l2_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b0), .TIMEOUT(8)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  l2_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b1), .TIMEOUT(8)) dut_prio (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.req_valid = 2'b00; bus0.req_addr = '0; bus0.req_write = 2'b00;
    bus0.req_wdata = '0; bus0.req_wstrb = '0; bus0.mem_req_ready = 1'b0;
    bus0.mem_resp_valid = 1'b0; bus0.mem_resp_rdata = '0;
    bus1.req_valid = 2'b00; bus1.req_addr = '0; bus1.req_write = 2'b00;
    bus1.req_wdata = '0; bus1.req_wstrb = '0; bus1.mem_req_ready = 1'b0;
    bus1.mem_resp_valid = 1'b0; bus1.mem_resp_rdata = '0;
  endtask

  task automatic set_req0(input logic port, input arb_req_t r);
    bus0.req_addr[port]  = r.addr;
    bus0.req_write[port] = r.write;
    bus0.req_wdata[port] = r.wdata;
    bus0.req_wstrb[port] = r.wstrb;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({bus0.req_ready, bus0.resp_valid, bus0.mem_req_valid, bus0.error} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl0: got %b want 000000", {bus0.req_ready, bus0.resp_valid, bus0.mem_req_valid, bus0.error}); end
    n_cmp++; if ({bus0.mem_addr, bus0.mem_wdata, bus0.mem_write, bus0.mem_wstrb, bus0.resp_rdata} !== '0) begin
      n_err++; $display("FAIL reset_data0: got addr %h wdata %h rdata %h want 0", bus0.mem_addr, bus0.mem_wdata, bus0.resp_rdata); end
    n_cmp++; if ({bus1.req_ready, bus1.resp_valid, bus1.mem_req_valid, bus1.error, bus1.mem_addr, bus1.resp_rdata} !== '0) begin
      n_err++; $display("FAIL reset_prio: got ctrl %b addr %h want 0", {bus1.req_ready, bus1.resp_valid, bus1.mem_req_valid, bus1.error}, bus1.mem_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_addr  [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000};
    logic [31:0] l2_data   [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    set_req0(ARB_PORT_FETCH, '{addr: 32'h1000, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    set_req0(ARB_PORT_DATA,  '{addr: 32'h2000, write: 1'b1, wdata: 32'h2222_2222, wstrb: 4'hF});
    for (int k = 0; k < 4; k++) begin
      bus0.req_valid      = (k < 3) ? 2'b11 : 2'b00;
      bus0.mem_resp_valid = 1'b0;
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (bus0.resp_valid !== exp_ready[k-1] || bus0.resp_rdata !== l2_data[k-1]) begin
          n_err++; $display("FAIL rr_resp%0d: got %b/%h want %b/%h", k-1, bus0.resp_valid, bus0.resp_rdata, exp_ready[k-1], l2_data[k-1]); end
      end
      if (k < 3) begin
        n_cmp++; if (bus0.req_ready !== exp_ready[k]) begin
          n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, bus0.req_ready, exp_ready[k]); end
      end
      tick();
      if (k < 3) begin
        bus0.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus0.mem_req_valid !== 1'b1 || bus0.mem_addr !== exp_addr[k]) begin
          n_err++; $display("FAIL rr_issue%0d: got valid %b addr %h want 1/%h", k, bus0.mem_req_valid, bus0.mem_addr, exp_addr[k]); end
        tick();
        bus0.mem_resp_valid = 1'b1;
        bus0.mem_resp_rdata = l2_data[k];
        @(negedge clk);
        n_cmp++; if (bus0.resp_valid !== 2'b00) begin
          n_err++; $display("FAIL rr_wait%0d: got %b want 00", k, bus0.resp_valid); end
        tick();
      end
    end
    clear_inputs();
  endtask

  task automatic test_data_prio();
    logic [31:0] l2_data [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    bus1.req_addr[0] = 32'h0000_1000;
    bus1.req_addr[1] = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      bus1.req_valid      = (k < 3) ? 2'b11 : 2'b00;
      bus1.mem_resp_valid = 1'b0;
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (bus1.resp_valid !== 2'b10 || bus1.resp_rdata !== l2_data[k-1]) begin
          n_err++; $display("FAIL prio_resp%0d: got %b/%h want 10/%h", k-1, bus1.resp_valid, bus1.resp_rdata, l2_data[k-1]); end
      end
      if (k < 3) begin
        n_cmp++; if (bus1.req_ready !== 2'b10) begin
          n_err++; $display("FAIL prio_grant%0d: got %b want 10", k, bus1.req_ready); end
      end
      tick();
      if (k < 3) begin
        bus1.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus1.mem_addr !== 32'h0000_2000) begin
          n_err++; $display("FAIL prio_addr%0d: got %h want 00002000", k, bus1.mem_addr); end
        tick();
        bus1.mem_resp_valid = 1'b1;
        bus1.mem_resp_rdata = l2_data[k];
        tick();
      end
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    set_req0(ARB_PORT_FETCH, '{addr: 32'h100, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus0.req_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (bus0.req_ready !== 2'b01 || bus0.mem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL single_accept: got ready %b mreq %b want 01/0", bus0.req_ready, bus0.mem_req_valid); end
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.mem_req_valid !== 1'b1 || bus0.mem_addr !== 32'h100 || bus0.mem_write !== 1'b0 || bus0.req_ready !== 2'b00) begin
      n_err++; $display("FAIL single_issue: got mreq %b addr %h wr %b want 1/00000100/0", bus0.mem_req_valid, bus0.mem_addr, bus0.mem_write); end
    tick();
    bus0.mem_req_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.mem_req_valid !== 1'b0 || bus0.resp_valid !== 2'b00) begin
      n_err++; $display("FAIL single_wait: got mreq %b resp %b want 0/00", bus0.mem_req_valid, bus0.resp_valid); end
    tick();
    bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b00) begin
      n_err++; $display("FAIL single_early: got %b want 00", bus0.resp_valid); end
    tick();
    bus0.mem_resp_valid = 1'b0; bus0.mem_resp_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b01 || bus0.resp_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_resp: got %b/%h want 01/deadbeef", bus0.resp_valid, bus0.resp_rdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b00) begin
      n_err++; $display("FAIL single_pulse: got %b want 00", bus0.resp_valid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    set_req0(ARB_PORT_DATA,  '{addr: 32'h300, write: 1'b1, wdata: 32'hCAFE_F00D, wstrb: 4'hC});
    set_req0(ARB_PORT_FETCH, '{addr: 32'h1000, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus0.req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus0.req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_accept: got %b want 10", bus0.req_ready); end
    tick();
    bus0.req_valid = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if ({bus0.mem_req_valid, bus0.mem_write, bus0.mem_wstrb, bus0.mem_addr, bus0.mem_wdata, bus0.req_ready}
                   !== {1'b1, 1'b1, 4'hC, 32'h300, 32'hCAFE_F00D, 2'b00}) begin
        n_err++; $display("FAIL bp_hold%0d: got mreq %b addr %h wdata %h ready %b want 1/00000300/cafef00d/00",
                          c, bus0.mem_req_valid, bus0.mem_addr, bus0.mem_wdata, bus0.req_ready); end
      tick();
    end
    bus0.mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.mem_req_valid !== 1'b1 || bus0.req_ready !== 2'b00) begin
      n_err++; $display("FAIL bp_release: got mreq %b ready %b want 1/00", bus0.mem_req_valid, bus0.req_ready); end
    tick();
    bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++; if (bus0.req_ready !== 2'b00 || bus0.mem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_wait: got ready %b mreq %b want 00/0", bus0.req_ready, bus0.mem_req_valid); end
    tick();
    bus0.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b10 || bus0.req_ready !== 2'b01) begin
      n_err++; $display("FAIL bp_resp: got resp %b ready %b want 10/01", bus0.resp_valid, bus0.req_ready); end
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.mem_addr !== 32'h1000) begin
      n_err++; $display("FAIL bp_next_addr: got %h want 00001000", bus0.mem_addr); end
    tick();
    bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'h5555_AAAA;
    tick();
    bus0.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b01 || bus0.resp_rdata !== 32'h5555_AAAA) begin
      n_err++; $display("FAIL bp_next_resp: got %b/%h want 01/5555aaaa", bus0.resp_valid, bus0.resp_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    set_req0(ARB_PORT_FETCH, '{addr: 32'h400, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus0.req_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (bus0.req_ready !== 2'b01) begin
      n_err++; $display("FAIL tmo_accept: got %b want 01", bus0.req_ready); end
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    tick();
    bus0.mem_req_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (bus0.resp_valid !== 2'b00 || bus0.error !== 1'b0) begin
        n_err++; $display("FAIL tmo_wait%0d: got resp %b err %b want 00/0", c, bus0.resp_valid, bus0.error); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b01 || bus0.resp_rdata !== 32'h0 || bus0.error !== 1'b1) begin
      n_err++; $display("FAIL tmo_fire: got %b/%h err %b want 01/00000000/1", bus0.resp_valid, bus0.resp_rdata, bus0.error); end
    tick();
    bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'hFFFF_FFFF;
    tick();
    bus0.mem_resp_valid = 1'b0;
    set_req0(ARB_PORT_DATA, '{addr: 32'h2000, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus0.req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b00 || bus0.error !== 1'b1 || bus0.req_ready !== 2'b10) begin
      n_err++; $display("FAIL tmo_stray: got resp %b err %b ready %b want 00/1/10", bus0.resp_valid, bus0.error, bus0.req_ready); end
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    tick();
    bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'h1357_9BDF;
    tick();
    bus0.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b10 || bus0.resp_rdata !== 32'h1357_9BDF || bus0.error !== 1'b1) begin
      n_err++; $display("FAIL tmo_sticky: got %b/%h err %b want 10/13579bdf/1", bus0.resp_valid, bus0.resp_rdata, bus0.error); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    set_req0(ARB_PORT_FETCH, '{addr: 32'h500, write: 1'b1, wdata: 32'h5050_5050, wstrb: 4'hF});
    bus0.req_valid = 2'b01;
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    tick();
    bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'h7777_7777;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus0.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus0.req_ready, bus0.resp_valid, bus0.mem_req_valid, bus0.error} !== 6'b0) begin
      n_err++; $display("FAIL rstw_ctrl: got %b want 000000", {bus0.req_ready, bus0.resp_valid, bus0.mem_req_valid, bus0.error}); end
    n_cmp++; if ({bus0.mem_addr, bus0.mem_wdata, bus0.mem_write, bus0.mem_wstrb, bus0.resp_rdata} !== '0) begin
      n_err++; $display("FAIL rstw_data: got addr %h wdata %h rdata %h want 0", bus0.mem_addr, bus0.mem_wdata, bus0.resp_rdata); end
    tick();
    set_req0(ARB_PORT_DATA, '{addr: 32'h600, write: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus0.req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus0.req_ready !== 2'b10 || bus0.resp_valid !== 2'b00) begin
      n_err++; $display("FAIL rstw_accept: got ready %b resp %b want 10/00", bus0.req_ready, bus0.resp_valid); end
    tick();
    bus0.req_valid = 2'b00; bus0.mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.mem_addr !== 32'h600 || bus0.mem_req_valid !== 1'b1) begin
      n_err++; $display("FAIL rstw_issue: got addr %h mreq %b want 00000600/1", bus0.mem_addr, bus0.mem_req_valid); end
    tick();
    bus0.mem_req_ready = 1'b0; bus0.mem_resp_valid = 1'b1; bus0.mem_resp_rdata = 32'h600D_CAFE;
    tick();
    bus0.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.resp_valid !== 2'b10 || bus0.resp_rdata !== 32'h600D_CAFE) begin
      n_err++; $display("FAIL rstw_resp: got %b/%h want 10/600dcafe", bus0.resp_valid, bus0.resp_rdata); end
    tick();
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_inputs();
    tick();
    tick();
    test_reset();
    test_round_robin();
    test_data_prio();
    test_single_read();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
